// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state encoding and owner codes for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: picks the winning requester; DMEM_ARB_RR_EN selects round-robin, otherwise CPU-first priority
module arb_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       win,
  output logic       any
);
`ifdef DMEM_ARB_RR_EN
  assign win = req[1] & (~req[0] | ptr);
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign win = req[1] & ~req[0];
`endif
  assign any = |req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between CPU and DMA; DMEM_ARB_RR_EN enables round-robin
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);
  localparam int CW = $clog2(MEM_LAT + 1);
  state_t          state_q, state_d;
  logic            owner_q, owner_d, we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            win, any, ptr, grant, acc, resp;
  arb_pick u_pick (.req({dma_req, cpu_req}), .ptr(ptr), .win(win), .any(any));
  assign grant = (state_q == IDLE) & any;
`ifdef DMEM_ARB_RR_EN
  logic ptr_q;
  assign ptr = ptr_q;
  // round-robin pointer hands priority to whichever side lost the last grant
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr_q <= OWN_CPU;
    else if (grant) ptr_q <= ~win;
`else
  assign ptr = OWN_CPU;
`endif
  // state and latched-request registers; reset drops any access in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  // next state: latch winner in IDLE, count down access cycles, then one response cycle
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = ACCESS;
        owner_d = win;
        we_d    = win ? dma_we : cpu_we;
        addr_d  = win ? dma_addr : cpu_addr;
        wdata_d = win ? dma_wdata : cpu_wdata;
        cnt_d   = CW'(MEM_LAT - 1);
      end
      ACCESS: if (cnt_q == '0) begin
        state_d = RESP;
        rdata_d = we_q ? '0 : mem_rdata;
      end else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
  assign acc       = state_q == ACCESS;
  assign resp      = state_q == RESP;
  assign mem_read  = acc & ~we_q;
  assign mem_write = acc & we_q;
  assign mem_addr  = acc ? addr_q : '0;
  assign mem_wdata = acc ? wdata_q : '0;
  assign cpu_ack   = resp & (owner_q == OWN_CPU);
  assign dma_ack   = resp & (owner_q == OWN_DMA);
  assign cpu_rdata = cpu_ack ? rdata_q : '0;
  assign dma_rdata = dma_ack ? rdata_q : '0;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = state_q != IDLE;
  assign owner     = busy & owner_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of the arbiter at MEM_LAT=1 (a_*) and MEM_LAT=3 (b_*)
module tb_dmem_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0, mem_rdata = 0;
  logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_addr, a_mem_wdata;
  logic        a_cpu_ack, a_cpu_stall, a_dma_ack, a_mem_read, a_mem_write, a_owner, a_busy;
  logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_addr, b_mem_wdata;
  logic        b_cpu_ack, b_cpu_stall, b_dma_ack, b_mem_read, b_mem_write, b_owner, b_busy;
  int          n_run = 0, n_fail = 0;
  int          lat;
  logic [3:0]  wins;
  always #5 clk = ~clk;
  dmem_arbiter #(.MEM_LAT(1)) u_a (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack), .cpu_stall(a_cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(a_dma_rdata), .dma_ack(a_dma_ack),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .owner(a_owner), .busy(a_busy));
  dmem_arbiter #(.MEM_LAT(3)) u_b (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack), .cpu_stall(b_cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .owner(b_owner), .busy(b_busy));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_rd", 32'(a_mem_read), 0);
    chk("rst_ack", 32'(a_cpu_ack), 0);
    chk("rst_addr", a_mem_addr, 0);
    reset = 1;
    @(negedge clk);
    mem_rdata = 32'hDEADBEEF; cpu_addr = 32'h10; cpu_we = 0; cpu_req = 1;
    #1;
    chk("t1_stall0", 32'(a_cpu_stall), 1);
    chk("t1_busy0", 32'(a_busy), 0);
    @(negedge clk);
    chk("t1_rd", 32'(a_mem_read), 1);
    chk("t1_wr", 32'(a_mem_write), 0);
    chk("t1_addr", a_mem_addr, 32'h10);
    chk("t1_stall1", 32'(a_cpu_stall), 1);
    chk("t1_ack1", 32'(a_cpu_ack), 0);
    @(negedge clk);
    chk("t1_ack", 32'(a_cpu_ack), 1);
    chk("t1_rdata", a_cpu_rdata, 32'hDEADBEEF);
    chk("t1_stall2", 32'(a_cpu_stall), 0);
    chk("t1_rd2", 32'(a_mem_read), 0);
    cpu_req = 0;
    @(negedge clk);
    chk("t1_idle", 32'(a_busy), 0);
    chk("t1_ack_end", 32'(a_cpu_ack), 0);
    dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678; dma_req = 1;
    @(negedge clk);
    chk("t2_wr", 32'(a_mem_write), 1);
    chk("t2_rd", 32'(a_mem_read), 0);
    chk("t2_addr", a_mem_addr, 32'h20);
    chk("t2_wdata", a_mem_wdata, 32'h12345678);
    chk("t2_owner", 32'(a_owner), 1);
    @(negedge clk);
    chk("t2_ack", 32'(a_dma_ack), 1);
    chk("t2_cpu_ack", 32'(a_cpu_ack), 0);
    chk("t2_rdata", a_dma_rdata, 0);
    chk("t2_wr_end", 32'(a_mem_write), 0);
    dma_req = 0; dma_we = 0;
    @(negedge clk);
    mem_rdata = 32'hA5A5A5A5; cpu_addr = 32'h30; dma_addr = 32'h40; cpu_req = 1; dma_req = 1;
    @(negedge clk);
    chk("t3_own1", 32'(a_owner), 0);
    chk("t3_addr1", a_mem_addr, 32'h30);
    @(negedge clk);
    chk("t3_cpu_ack", 32'(a_cpu_ack), 1);
    chk("t3_dma_ack_early", 32'(a_dma_ack), 0);
    cpu_req = 0;
    @(negedge clk);
    chk("t3_idle", 32'(a_busy), 0);
    @(negedge clk);
    chk("t3_own2", 32'(a_owner), 1);
    chk("t3_addr2", a_mem_addr, 32'h40);
    @(negedge clk);
    chk("t3_dma_ack", 32'(a_dma_ack), 1);
    chk("t3_dma_rdata", a_dma_rdata, 32'hA5A5A5A5);
    chk("t3_cpu_ack2", 32'(a_cpu_ack), 0);
    dma_req = 0;
    @(negedge clk);
    cpu_req = 1; dma_req = 1;
    wins = '0;
    for (int g = 0; g < 4; g++) begin
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (a_cpu_ack | a_dma_ack) begin
          lat = i;
          break;
        end
      end
      chk("arb_grant_seen", 32'(lat != 0), 1);
      wins[g] = a_dma_ack;
    end
`ifdef DMEM_ARB_RR_EN
    chk("arb_rr_order", 32'(wins), 32'b1010);
`else
    chk("arb_fixed_order", 32'(wins), 32'b0000);
`endif
    cpu_req = 0; dma_req = 0;
    reset = 0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(b_busy), 0);
    reset = 1;
    @(negedge clk);
    mem_rdata = 32'h0BADF00D; cpu_addr = 32'h50; cpu_we = 0; cpu_req = 1;
    @(negedge clk);
    chk("t4_rd1", 32'(b_mem_read), 1);
    chk("t4_addr1", b_mem_addr, 32'h50);
    cpu_addr = 32'h99;
    @(negedge clk);
    chk("t4_rd2", 32'(b_mem_read), 1);
    chk("t4_addr_hold", b_mem_addr, 32'h50);
    @(negedge clk);
    chk("t4_rd3", 32'(b_mem_read), 1);
    chk("t4_ack_early", 32'(b_cpu_ack), 0);
    @(negedge clk);
    chk("t4_ack", 32'(b_cpu_ack), 1);
    chk("t4_rdata", b_cpu_rdata, 32'h0BADF00D);
    chk("t4_rd_end", 32'(b_mem_read), 0);
    cpu_req = 0;
    @(negedge clk);
    chk("t4_idle", 32'(b_busy), 0);
    cpu_addr = 32'h60; cpu_req = 1;
    @(negedge clk);
    chk("t5_rd", 32'(b_mem_read), 1);
    reset = 0;
    #1;
    chk("t5_rd_drop", 32'(b_mem_read), 0);
    chk("t5_busy_drop", 32'(b_busy), 0);
    chk("t5_ack_none", 32'(b_cpu_ack), 0);
    repeat (2) @(negedge clk);
    chk("t5_ack_in_rst", 32'(b_cpu_ack), 0);
    reset = 1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (b_cpu_ack) begin
        lat = i;
        break;
      end
    end
    chk("t5_latency", 32'(lat), 4);
    chk("t5_rdata", b_cpu_rdata, 32'h0BADF00D);
    cpu_req = 0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
